// File: rtl/upsample_2x2_stream.sv
// 2x2 nearest-neighbour / zero-insert upsampler for 22-bit signed raster streams.
// Each input row is emitted twice. The bottom copy is replayed from a one-row line buffer.
module upsample_2x2_stream #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_HEIGHT = 16,
  parameter bit ZERO_FILL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_signal,
  input  logic               pixel_valid,
  input  logic signed [21:0] pixel_in,
  output logic               in_ready,
  output logic signed [21:0] result_out,
  output logic               result_valid,
  output logic               result_last,
  output logic               done_signal,
  output logic               busy
);

  localparam int XW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ROW_TOP, ROW_BOT, DONE} state_t;

  state_t             state;
  logic [XW-1:0]      in_x;
  logic [YW-1:0]      in_y;
  logic               dup;
  logic signed [21:0] hold;
  logic signed [21:0] line_buf [IN_WIDTH];
  logic               accept;

  assign in_ready = (state == ROW_TOP) && !dup;
  assign accept   = in_ready && pixel_valid;
  assign busy     = (state != IDLE);

  // The line buffer is deliberately left out of reset. Every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) line_buf[in_x] <= pixel_in;
  end

  // done_signal is raised while leaving DONE, so it lands the cycle after result_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_x         <= '0;
      in_y         <= '0;
      dup          <= 1'b0;
      hold         <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
      done_signal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          result_last  <= 1'b0;
          done_signal  <= 1'b0;
          if (start_signal) begin
            state <= ROW_TOP;
            in_x  <= '0;
            in_y  <= '0;
            dup   <= 1'b0;
          end
        end
        ROW_TOP: begin
          result_last <= 1'b0;
          done_signal <= 1'b0;
          if (!dup) begin
            if (accept) begin
              hold         <= pixel_in;
              result_out   <= pixel_in;
              result_valid <= 1'b1;
              dup          <= 1'b1;
            end else begin
              result_valid <= 1'b0;
            end
          end else begin
            result_out   <= ZERO_FILL ? '0 : hold;
            result_valid <= 1'b1;
            dup          <= 1'b0;
            if (in_x == X_LAST) begin
              in_x  <= '0;
              state <= ROW_BOT;
            end else begin
              in_x <= in_x + 1'b1;
            end
          end
        end
        ROW_BOT: begin
          done_signal  <= 1'b0;
          result_out   <= ZERO_FILL ? '0 : line_buf[in_x];
          result_valid <= 1'b1;
          dup          <= ~dup;
          if (dup) begin
            if (in_x == X_LAST) begin
              in_x <= '0;
              dup  <= 1'b0;
              if (in_y == Y_LAST) begin
                state       <= DONE;
                result_last <= 1'b1;
              end else begin
                in_y  <= in_y + 1'b1;
                state <= ROW_TOP;
              end
            end else begin
              in_x <= in_x + 1'b1;
            end
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          result_last  <= 1'b0;
          done_signal  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_2x2_stream.sv
// Self-checking bench for upsample_2x2_stream on a 4x2 frame.
// Replicate and zero-fill instances share one input stream.
module tb_upsample_2x2_stream;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  typedef logic signed [21:0] frame_t [N];

  logic               clk = 1'b0;
  logic               rst;
  logic               start_signal;
  logic               pixel_valid;
  logic signed [21:0] pixel_in;
  logic               in_ready, result_valid, result_last, done_signal, busy;
  logic signed [21:0] result_out;
  logic               z_in_ready, z_valid, z_last, z_done, z_busy;
  logic signed [21:0] z_out;

  upsample_2x2_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .ZERO_FILL(1'b0)) dut (
    .clk(clk), .rst(rst), .start_signal(start_signal), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .in_ready(in_ready), .result_out(result_out),
    .result_valid(result_valid), .result_last(result_last),
    .done_signal(done_signal), .busy(busy));

  upsample_2x2_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .ZERO_FILL(1'b1)) dut_zf (
    .clk(clk), .rst(rst), .start_signal(start_signal), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .in_ready(z_in_ready), .result_out(z_out),
    .result_valid(z_valid), .result_last(z_last),
    .done_signal(z_done), .busy(z_busy));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [21:0] exp_q[$];
  logic signed [21:0] exp_zq[$];
  logic signed [21:0] cap[$];
  int  acc_cnt = 0;
  int  out_cnt = 0;
  int  zf_nonzero = 0;
  int  zf_sum = 0;
  bit  done_due = 1'b0;
  bit  zdone_due = 1'b0;

  localparam int T1_EXP [32] = '{1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4,
                                 5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8};

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Upsampled image in raster order: each pixel fills a 2x2 block, or only its top-left corner in zero-fill.
  function automatic void build_frame(input frame_t pix);
    for (int y = 0; y < H; y++)
      for (int r = 0; r < 2; r++)
        for (int x = 0; x < W; x++)
          for (int c = 0; c < 2; c++) begin
            exp_q.push_back(pix[y*W+x]);
            exp_zq.push_back((r == 0 && c == 0) ? pix[y*W+x] : 22'sd0);
          end
  endfunction

  always @(posedge clk) begin
    if (!rst && pixel_valid && in_ready) acc_cnt++;
  end

  // Per-cycle compare against the model queues, done pulse timing, and input-window rule.
  always @(negedge clk) begin
    if (rst) begin
      done_due  = 1'b0;
      zdone_due = 1'b0;
    end else begin
      checkOutput("done_signal", done_signal, done_due);
      checkOutput("zf_done_signal", z_done, zdone_due);
      done_due  = 1'b0;
      zdone_due = 1'b0;
      if (result_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          checkOutput("result_out", result_out, exp_q.pop_front());
          cap.push_back(result_out);
          checkOutput("result_last", result_last, exp_q.size() == 0);
          done_due = (exp_q.size() == 0);
        end
      end
      if (z_valid) begin
        if (exp_zq.size() == 0) begin
          checkOutput("zf_unexpected_valid", 1, 0);
        end else begin
          checkOutput("zf_result_out", z_out, exp_zq.pop_front());
          if (z_out != 0) zf_nonzero++;
          zf_sum += int'(z_out);
          checkOutput("zf_result_last", z_last, exp_zq.size() == 0);
          zdone_due = (exp_zq.size() == 0);
        end
      end
      if (in_ready)
        checkOutput("in_ready_window", out_cnt, 4*W*(acc_cnt/W) + 2*(acc_cnt%W));
    end
  end

  task automatic applyStimulus(input frame_t pix, input bit rand_valid, input int abort_after,
                               input bit poke_mid, input bit poke_done);
    int  guard;
    bit  accepted;
    @(negedge clk);
    exp_q.delete(); exp_zq.delete(); cap.delete();
    acc_cnt = 0; out_cnt = 0; zf_nonzero = 0; zf_sum = 0;
    build_frame(pix);
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      guard = 0;
      accepted = 1'b0;
      while (!accepted && guard < 200) begin
        if (abort_after > 0 && out_cnt >= abort_after) begin
          rst = 1'b1; pixel_valid = 1'b0; start_signal = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          exp_q.delete(); exp_zq.delete();
          checkOutput("busy_after_rst", busy, 0);
          checkOutput("valid_after_rst", result_valid, 0);
          checkOutput("done_after_rst", done_signal, 0);
          checkOutput("in_ready_after_rst", in_ready, 0);
          return;
        end
        pixel_in     = pix[i];
        pixel_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        start_signal = poke_mid && (i == 5);
        accepted     = pixel_valid && in_ready;
        @(negedge clk);
        guard++;
      end
      if (!accepted) begin
        checkOutput("input_accept_timeout", 0, 1);
        pixel_valid = 1'b0;
        return;
      end
    end
    pixel_valid  = 1'b0;
    start_signal = 1'b0;
    guard = 0;
    while (!done_signal && guard < 200) begin
      start_signal = poke_done && result_valid && result_last;
      @(negedge clk);
      guard++;
    end
    start_signal = 1'b0;
    checkOutput("done_seen", done_signal, 1);
    checkOutput("busy_at_done", busy, 0);
    checkOutput("outputs_left", exp_q.size(), 0);
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic compare_ramp(input string tag);
    checkOutput({tag, "_count"}, cap.size(), 32);
    for (int k = 0; k < 32 && k < cap.size(); k++)
      checkOutput({tag, "_pixel"}, cap[k], T1_EXP[k]);
  endtask

  frame_t ramp, negs;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) ramp[i] = 22'(i + 1);
    negs = '{22'(-3), 22'(-2097152), 22'(2097151), 22'(0),
             22'(5), 22'(-1), 22'(100), 22'(-100)};
    rst = 1'b1; start_signal = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_valid", result_valid, 0);
    checkOutput("reset_last", result_last, 0);
    checkOutput("reset_done", done_signal, 0);
    checkOutput("reset_out", result_out, 0);

    $display("[TB] test 1: ramp, valid held high");
    applyStimulus(ramp, 1'b0, 0, 1'b0, 1'b0);
    compare_ramp("t1");
    checkOutput("t3_zf_nonzero", zf_nonzero, 8);
    checkOutput("t3_zf_sum", zf_sum, 36);

    $display("[TB] test 2: signed extremes");
    applyStimulus(negs, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("t2_out0", cap[0], -3);
    checkOutput("t2_out1", cap[1], -3);
    checkOutput("t2_out2", cap[2], -2097152);
    checkOutput("t2_out4", cap[4], 2097151);
    checkOutput("t2_out8", cap[8], -3);
    checkOutput("t2_out19", cap[19], -1);
    checkOutput("t2_out31", cap[31], -100);

    $display("[TB] test 4: random input stalls, start pulsed mid-frame");
    applyStimulus(ramp, 1'b1, 0, 1'b1, 1'b0);
    compare_ramp("t4");

    $display("[TB] test 5: reset mid-frame, then full frame with start in DONE cycle");
    applyStimulus(ramp, 1'b0, 10, 1'b0, 1'b0);
    applyStimulus(ramp, 1'b0, 0, 1'b0, 1'b1);
    compare_ramp("t5");

    $display("[TB] test 6: second back-to-back frame");
    applyStimulus(ramp, 1'b0, 0, 1'b0, 1'b0);
    compare_ramp("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
